mem_io_sequencer: RTL and testbench

Multi-cycle access sequencer between the single-cycle CPU's load/store stage and its two data targets: block-RAM data memory and the memory-mapped I/O bus (LED, switch, seven-segment, timer). It decodes each CPU access, inserts the block-RAM wait state, and runs a chip-select/acknowledge handshake with slow I/O devices, holding the CPU with `cpu_stall` until data is ready. An optional timeout recovers from a device that never acknowledges.

---
 rtl/mem_io_sequencer.sv | 148 ++++++++++++++
 tb/tb_mem_io_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_sequencer.sv
// mem_io_sequencer: multi-cycle access sequencer between the CPU load/store
// stage and its two data targets (block-RAM data memory and the I/O bus).
// Each CPU access is decoded and the block-RAM wait state is inserted.
// Slow I/O devices get a chip-select/acknowledge handshake.
// The CPU is held on cpu_stall until the access completes.
// Optional feature macro: MEM_IO_TIMEOUT_EN aborts an I/O access when the
// device does not acknowledge within TIMEOUT cycles.
module mem_io_sequencer #(
    parameter logic [31:0] IO_BASE  = 32'hFFFF_FC00,
    parameter int          MEM_WAIT = 1,
    parameter logic [7:0]  TIMEOUT  = 8'd15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  io_cs,
    output logic        io_we,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    input  logic        io_ack
);

    typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;

    state_t     state;
    logic       we_q;
    logic [1:0] wait_cnt;

`ifdef MEM_IO_TIMEOUT_EN
    logic [7:0] to_cnt;
`else
    // TIMEOUT only matters when the abort counter is built
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // The I/O region is a 1 KiB window selected by the upper address bits
    function automatic logic is_io(input logic [31:0] a);
        return a[31:10] == IO_BASE[31:10];
    endfunction

    // Only devices 0..3 exist; bits [7:6] must be zero for a mapped device
    function automatic logic io_mapped(input logic [31:0] a);
        return a[7:6] == 2'b00;
    endfunction

    // Stall while an access is being accepted or is in flight; DONE releases the CPU
    assign cpu_stall = !reset &&
                       (((state == IDLE) && cpu_req) || (state == MEM) || (state == IO));

    // Access sequencer: decode, memory wait states, I/O handshake, completion
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            wait_cnt  <= 2'd0;
            cpu_rdata <= 32'h0;
            cpu_err   <= 1'b0;
            mem_addr  <= 32'h0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'h0;
            io_cs     <= 4'b0000;
            io_we     <= 1'b0;
            io_wdata  <= 16'h0;
`ifdef MEM_IO_TIMEOUT_EN
            to_cnt    <= 8'd0;
`endif
        end else begin
            // Strobes are single-cycle unless a state below re-asserts them
            cpu_err <= 1'b0;
            mem_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        io_wdata  <= cpu_wdata[15:0];
                        we_q      <= cpu_we;
                        if (is_io(cpu_addr)) begin
                            if (io_mapped(cpu_addr)) begin
                                state  <= IO;
                                io_cs  <= 4'b0001 << cpu_addr[5:4];
                                io_we  <= cpu_we;
`ifdef MEM_IO_TIMEOUT_EN
                                to_cnt <= 8'd0;
`endif
                            end else begin
                                // Unmapped device: complete at once with an error
                                state     <= DONE;
                                cpu_rdata <= 32'h0;
                                cpu_err   <= 1'b1;
                            end
                        end else begin
                            // Write enable covers only the first MEM cycle
                            state    <= MEM;
                            mem_we   <= cpu_we;
                            wait_cnt <= 2'(MEM_WAIT - 1);
                        end
                    end
                end
                MEM: begin
                    if (wait_cnt == 2'd0) begin
                        if (!we_q) cpu_rdata <= mem_rdata;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                IO: begin
                    // An ack in the expiring cycle takes priority over the abort
                    if (io_ack) begin
                        if (!we_q) cpu_rdata <= {16'h0000, io_rdata};
                        io_cs <= 4'b0000;
                        io_we <= 1'b0;
                        state <= DONE;
                    end
`ifdef MEM_IO_TIMEOUT_EN
                    else if (to_cnt == TIMEOUT - 8'd1) begin
                        io_cs     <= 4'b0000;
                        io_we     <= 1'b0;
                        cpu_rdata <= 32'h0;
                        cpu_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    // The CPU retires here; a still-high cpu_req is not re-accepted
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_sequencer.sv
// tb_mem_io_sequencer: directed bench with a scoreboard of expected
// completions for mem_io_sequencer.
module tb_mem_io_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  io_cs;
    logic        io_we;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        io_ack;

    always #5 clock = ~clock;

    mem_io_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cpu_err   (cpu_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .io_cs     (io_cs),
        .io_we     (io_we),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ack    (io_ack)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic err, input int stalls);
        exp_t e;
        e.rdata  = rdata;
        e.err    = err;
        e.stalls = stalls;
        sb.push_back(e);
        model_rdata = rdata;
    endtask

    // One CPU access: ack_at = IO cycle carrying io_ack (0 = never)
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_at,
                          input logic [3:0] exp_cs, input int exp_cs_cycles,
                          input int exp_mem_we_cycles);
        int          n = 0;
        int          cs_cyc = 0;
        int          mwe_cyc = 0;
        logic [3:0]  seen_cs = 4'b0;
        logic        seen_iowe = 1'b0;
        logic [15:0] seen_iowd = 16'h0;
        logic [31:0] seen_maddr = 32'h0;
        logic [31:0] seen_mwd = 32'h0;
        exp_t        e;
        @(negedge clock);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        io_ack    = 1'b0;
        forever begin
            #1;
            if (!cpu_stall) break;
            n++;
            if (io_cs != 4'b0) begin
                cs_cyc++;
                seen_cs   = io_cs;
                seen_iowe = io_we;
                seen_iowd = io_wdata;
            end
            if (mem_we) begin
                mwe_cyc++;
                seen_maddr = mem_addr;
                seen_mwd   = mem_wdata;
            end
            io_ack = (ack_at > 0) && (n == ack_at + 1);
            if (n > 100) begin
                chk({tag, "_bound"}, 32'(n), 32'd100);
                break;
            end
            @(negedge clock);
        end
        io_ack = 1'b0;
        e = sb.pop_front();
        chk({tag, "_stalls"}, 32'(n), 32'(e.stalls));
        chk({tag, "_rdata"}, cpu_rdata, e.rdata);
        chk({tag, "_err"}, 32'(cpu_err), 32'(e.err));
        chk({tag, "_cs_cycles"}, 32'(cs_cyc), 32'(exp_cs_cycles));
        chk({tag, "_mem_we_cycles"}, 32'(mwe_cyc), 32'(exp_mem_we_cycles));
        if (exp_cs_cycles > 0) begin
            chk({tag, "_cs"}, 32'(seen_cs), 32'(exp_cs));
            chk({tag, "_io_we"}, 32'(seen_iowe), 32'(we));
            if (we) chk({tag, "_io_wdata"}, 32'(seen_iowd), 32'(wdata[15:0]));
        end
        if (exp_mem_we_cycles > 0) begin
            chk({tag, "_mem_addr"}, seen_maddr, addr);
            chk({tag, "_mem_wdata"}, seen_mwd, wdata);
        end
        cpu_req = 1'b0;
        @(negedge clock);
        #1;
        chk({tag, "_err_clear"}, 32'(cpu_err), 32'd0);
        chk({tag, "_idle_stall"}, 32'(cpu_stall), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        mem_rdata = 32'h1234_5678;
        io_rdata  = 16'hA5A5;
        io_ack    = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_err", 32'(cpu_err), 32'd0);
        chk("rst_io_cs", 32'(io_cs), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b0;

        // Memory load: two stall cycles, data from block RAM
        push_exp(32'h1234_5678, 1'b0, 2);
        access("mem_load", 1'b0, 32'h0000_0010, 32'h0, 0, 4'b0, 0, 0);

        // Memory store: one mem_we cycle, cpu_rdata unchanged
        push_exp(model_rdata, 1'b0, 2);
        access("mem_store", 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 0, 4'b0, 0, 1);

        // Switch read with ack on the third IO cycle
        io_rdata = 16'hA5A5;
        push_exp(32'h0000_A5A5, 1'b0, 4);
        access("sw_read", 1'b0, 32'hFFFF_FC10, 32'h0, 3, 4'b0010, 3, 0);

        // Timer read with immediate ack
        io_rdata = 16'h3C3C;
        push_exp(32'h0000_3C3C, 1'b0, 2);
        access("tmr_read", 1'b0, 32'hFFFF_FC30, 32'h0, 1, 4'b1000, 1, 0);

        // LED write acked on second IO cycle; load result is kept
        push_exp(model_rdata, 1'b0, 3);
        access("led_write", 1'b1, 32'hFFFF_FC00, 32'h0000_1357, 2, 4'b0001, 2, 0);

        // Unmapped I/O device
        push_exp(32'h0, 1'b1, 1);
        access("unmapped", 1'b0, 32'hFFFF_FC50, 32'h0, 0, 4'b0, 0, 0);

        // io_ack while idle is ignored
        @(negedge clock);
        io_ack = 1'b1;
        @(negedge clock);
        #1;
        chk("stray_ack_stall", 32'(cpu_stall), 32'd0);
        chk("stray_ack_cs", 32'(io_cs), 32'd0);
        chk("stray_ack_err", 32'(cpu_err), 32'd0);
        io_ack = 1'b0;

`ifdef MEM_IO_TIMEOUT_EN
        // Device never acks: abort after 15 IO cycles
        push_exp(32'h0, 1'b1, 16);
        access("timeout", 1'b1, 32'hFFFF_FC00, 32'h0000_00FF, 0, 4'b0001, 15, 0);

        // Ack in the expiring cycle wins
        io_rdata = 16'h5AA5;
        push_exp(32'h0000_5AA5, 1'b0, 16);
        access("ack_at_limit", 1'b0, 32'hFFFF_FC10, 32'h0, 15, 4'b0010, 15, 0);
`endif

        // Reset in the second IO cycle of a seg write
        @(negedge clock);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'hFFFF_FC20;
        cpu_wdata = 32'h0000_00AA;
        @(negedge clock);
        #1;
        chk("seg_io_cs", 32'(io_cs), 32'h4);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("midrst_io_cs", 32'(io_cs), 32'd0);
        chk("midrst_io_we", 32'(io_we), 32'd0);
        chk("midrst_stall", 32'(cpu_stall), 32'd0);
        reset   = 1'b0;
        cpu_req = 1'b0;
        model_rdata = 32'h0;

        // The next access after reset proceeds normally
        mem_rdata = 32'hCAFE_F00D;
        push_exp(32'hCAFE_F00D, 1'b0, 2);
        access("post_rst_load", 1'b0, 32'h0000_0100, 32'h0, 0, 4'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
